// File: rtl/team_12_wb_regif_pkg.sv
// Register offsets, STATUS bit positions and the STATUS word layout shared
// by the team_12 Wishbone register front-end.
package team_12_regif_pkg;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_TX     = 4'h8;
  localparam logic [3:0] REG_RX     = 4'hC;

  localparam int CTRL_SOFT_CLR = 0;
  localparam int CTRL_IRQ_EN   = 1;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_RX_FULL  = 2;
  localparam int STAT_RX_EMPTY = 3;
  localparam int STAT_TX_OVF   = 4;
  localparam int STAT_RX_UNF   = 5;

  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] rx_count;
    logic [7:0] tx_count;
    logic [1:0] rsvd_lo;
    logic       rx_unf;
    logic       tx_ovf;
    logic       rx_empty;
    logic       rx_full;
    logic       tx_empty;
    logic       tx_full;
  } status_t;

endpackage

// File: rtl/team_12_wb_regif_if.sv
// Wishbone classic slave-side bus bundle; names follow the wrapper's wbs_* pins.
interface team_12_wb_regif_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/team_12_sync_fifo.sv
// Single-clock FIFO with flush; a push while full or pop while empty is ignored,
// and full/empty always reflect the state before this cycle's operations.
module team_12_sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push, do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/team_12_wb_regif.sv
// Wishbone classic register window (CTRL/STATUS/TX_DATA/RX_DATA) bridging to core
// TX/RX streams. Define TEAM_12_WB_REGIF_IRQ_EN to add the registered irq_o output.
module team_12_wb_regif
  import team_12_regif_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          DW         = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                nrst,
  team_12_wb_regif_if.slave   wb,
  output logic [31:0]         ctrl_o,
  output logic [DW-1:0]       tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  input  logic [DW-1:0]       rx_data_i,
  input  logic                rx_valid_i,
  output logic                rx_ready_o
`ifdef TEAM_12_WB_REGIF_IRQ_EN
  ,
  output logic                irq_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ack_reg, tx_ovf_reg, rx_unf_reg;
  logic [31:0]   dat_reg, ctrl_reg, rd_data, byte_mask;
  logic          accept, wr, rd, soft_clr, tx_wr, rx_rd, stat_wr;
  logic [3:0]    reg_off;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [DW-1:0] rx_head;
  status_t       status;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
    assign byte_mask[gi*8 +: 8] = {8{wb.wbs_sel_i[gi]}};
  end

  // Holding off while ack is high makes every transfer exactly one accept.
  assign accept   = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_reg &
                    (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr       = accept & wb.wbs_we_i;
  assign rd       = accept & ~wb.wbs_we_i;
  assign reg_off  = {wb.wbs_adr_i[3:2], 2'b00};
  assign soft_clr = wr & (reg_off == REG_CTRL) & wb.wbs_sel_i[0] & wb.wbs_dat_i[CTRL_SOFT_CLR];
  assign stat_wr  = wr & (reg_off == REG_STATUS) & wb.wbs_sel_i[0];
  assign tx_wr    = wr & (reg_off == REG_TX);
  assign rx_rd    = rd & (reg_off == REG_RX);

  team_12_sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .nrst(nrst), .flush(soft_clr),
    .push(tx_wr), .pop(tx_ready_i), .din(wb.wbs_dat_i[DW-1:0]),
    .dout(tx_data_o), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  team_12_sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .nrst(nrst), .flush(soft_clr),
    .push(rx_valid_i & rx_ready_o), .pop(rx_rd), .din(rx_data_i),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign tx_valid_o = ~tx_empty;
  assign rx_ready_o = ~rx_full;
  assign ctrl_o     = ctrl_reg;

  always_comb begin
    status          = '0;
    status.tx_full  = tx_full;
    status.tx_empty = tx_empty;
    status.rx_full  = rx_full;
    status.rx_empty = rx_empty;
    status.tx_ovf   = tx_ovf_reg;
    status.rx_unf   = rx_unf_reg;
    status.tx_count = 8'(tx_count);
    status.rx_count = 8'(rx_count);
  end

  always_comb begin
    rd_data = '0;
    unique case (reg_off)
      REG_CTRL:   rd_data = ctrl_reg;
      REG_STATUS: rd_data = status;
      REG_RX:     rd_data = rx_empty ? 32'h0 : 32'(rx_head);
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ack_reg    <= 1'b0;
      dat_reg    <= '0;
      ctrl_reg   <= '0;
      tx_ovf_reg <= 1'b0;
      rx_unf_reg <= 1'b0;
    end else begin
      ack_reg <= accept;
      dat_reg <= rd ? rd_data : 32'h0;
      // soft_clr is an action, never stored, so bit0 always reads back 0.
      if (wr && reg_off == REG_CTRL)
        ctrl_reg <= ((ctrl_reg & ~byte_mask) | (wb.wbs_dat_i & byte_mask)) & 32'hFFFF_FFFE;
      if (soft_clr) begin
        tx_ovf_reg <= 1'b0;
        rx_unf_reg <= 1'b0;
      end else begin
        if (tx_wr && tx_full)                          tx_ovf_reg <= 1'b1;
        else if (stat_wr && wb.wbs_dat_i[STAT_TX_OVF]) tx_ovf_reg <= 1'b0;
        if (rx_rd && rx_empty)                         rx_unf_reg <= 1'b1;
        else if (stat_wr && wb.wbs_dat_i[STAT_RX_UNF]) rx_unf_reg <= 1'b0;
      end
    end
  end

  assign wb.wbs_ack_o = ack_reg;
  assign wb.wbs_dat_o = dat_reg;

`ifdef TEAM_12_WB_REGIF_IRQ_EN
  logic irq_reg;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) irq_reg <= 1'b0;
    else       irq_reg <= ctrl_reg[CTRL_IRQ_EN] & (~rx_empty | tx_ovf_reg | rx_unf_reg);
  end
  assign irq_o = irq_reg;
`endif
endmodule

// File: tb/tb_team_12_wb_regif.sv
// Self-checking bench for team_12_wb_regif: directed register scenarios followed by
// randomized bus and core traffic, checked every cycle against a queue-based model.
module tb_team_12_wb_regif;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DW    = 16;
  localparam int          DEPTH = 4;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [31:0]   ctrl_o;
  logic [DW-1:0] tx_data_o, rx_data;
  logic          tx_valid_o, tx_ready, rx_valid, rx_ready_o;
`ifdef TEAM_12_WB_REGIF_IRQ_EN
  logic          irq_o;
`endif

  always #5 clk = ~clk;

  team_12_wb_regif_if wb ();

  team_12_wb_regif #(.BASE_ADDR(BASE), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .wb(wb), .ctrl_o(ctrl_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_o)
`ifdef TEAM_12_WB_REGIF_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [DW-1:0] q_tx[$];
  bit [DW-1:0] q_rx[$];
  bit [31:0]   m_ctrl, m_dat, rdv;
  bit          m_ack, m_ovf, m_unf, m_irq;
  bit          acc, clr, tx_out, rx_in, push_tx, pop_rx;
  bit [3:0]    off;

  function automatic bit [31:0] status_now();
    bit [31:0] s = 32'h0;
    s[0]     = (q_tx.size() == DEPTH);
    s[1]     = (q_tx.size() == 0);
    s[2]     = (q_rx.size() == DEPTH);
    s[3]     = (q_rx.size() == 0);
    s[4]     = m_ovf;
    s[5]     = m_unf;
    s[15:8]  = 8'(q_tx.size());
    s[23:16] = 8'(q_rx.size());
    return s;
  endfunction

  initial forever begin
    @(posedge clk or negedge nrst);
    if (!nrst) begin
      q_tx.delete(); q_rx.delete();
      m_ctrl = 0; m_dat = 0; m_ack = 0; m_ovf = 0; m_unf = 0; m_irq = 0;
    end else begin
      tx_out  = (q_tx.size() > 0) && tx_ready;
      rx_in   = rx_valid && (q_rx.size() < DEPTH);
      m_irq   = m_ctrl[1] && ((q_rx.size() > 0) || m_ovf || m_unf);
      acc     = wb.wbs_cyc_i && wb.wbs_stb_i && !m_ack && (wb.wbs_adr_i[31:4] == BASE[31:4]);
      off     = {wb.wbs_adr_i[3:2], 2'b00};
      clr = 0; rdv = 0; push_tx = 0; pop_rx = 0;
      if (acc) begin
        case (off)
          4'h0: if (wb.wbs_we_i) begin
                  for (int b = 0; b < 4; b++)
                    if (wb.wbs_sel_i[b]) m_ctrl[b*8 +: 8] = wb.wbs_dat_i[b*8 +: 8];
                  m_ctrl[0] = 0;
                  clr = wb.wbs_sel_i[0] && wb.wbs_dat_i[0];
                end else rdv = m_ctrl;
          4'h4: if (wb.wbs_we_i) begin
                  if (wb.wbs_sel_i[0] && wb.wbs_dat_i[4]) m_ovf = 0;
                  if (wb.wbs_sel_i[0] && wb.wbs_dat_i[5]) m_unf = 0;
                end else rdv = status_now();
          4'h8: if (wb.wbs_we_i) begin
                  if (q_tx.size() == DEPTH) m_ovf = 1;
                  else push_tx = 1;
                end
          default: if (!wb.wbs_we_i) begin
                  if (q_rx.size() == 0) m_unf = 1;
                  else begin rdv = 32'(q_rx[0]); pop_rx = 1; end
                end
        endcase
      end
      if (clr) begin
        q_tx.delete(); q_rx.delete(); m_ovf = 0; m_unf = 0;
      end else begin
        if (tx_out)  void'(q_tx.pop_front());
        if (push_tx) q_tx.push_back(wb.wbs_dat_i[DW-1:0]);
        if (pop_rx)  void'(q_rx.pop_front());
        if (rx_in)   q_rx.push_back(rx_data);
      end
      m_ack = acc;
      m_dat = rdv;
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("ack", 32'(wb.wbs_ack_o), 32'(m_ack));
    chk("dat_o", wb.wbs_dat_o, m_dat);
    chk("tx_valid", 32'(tx_valid_o), 32'(q_tx.size() != 0));
    if (q_tx.size() != 0) chk("tx_data", 32'(tx_data_o), 32'(q_tx[0]));
    chk("rx_ready", 32'(rx_ready_o), 32'(q_rx.size() < DEPTH));
    chk("ctrl_o", ctrl_o, m_ctrl);
`ifdef TEAM_12_WB_REGIF_IRQ_EN
    chk("irq", 32'(irq_o), 32'(m_irq));
`endif
  end

  // ---------------- stimulus ----------------
  int lat;

  task automatic bus(input bit we, input bit [3:0] o, input bit [31:0] dat,
                     input bit [3:0] sel, output bit [31:0] rd);
    bit got = 0;
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = we;
    wb.wbs_adr_i = BASE + 32'(o); wb.wbs_dat_i = dat; wb.wbs_sel_i = sel;
    rd = 0; lat = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (wb.wbs_ack_o) begin got = 1; rd = wb.wbs_dat_o; end
    end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    if (!got) chk("bus_ack_timeout", 32'(got), 32'd1);
    $display("bus we=%0d off=%h dat=%h sel=%h rd=%h", we, o, dat, sel, rd);
  endtask

  task automatic wr(input bit [3:0] o, input bit [31:0] dat, input bit [3:0] sel);
    bit [31:0] dummy;
    bus(1'b1, o, dat, sel, dummy);
  endtask

  task automatic rd_chk(input string nm, input bit [3:0] o, input bit [31:0] exp);
    bit [31:0] v;
    bus(1'b0, o, 32'h0, 4'hF, v);
    chk(nm, v, exp);
  endtask

  task automatic core_push(input bit [DW-1:0] d);
    rx_valid = 1; rx_data = d;
    @(negedge clk);
    rx_valid = 0;
  endtask

  initial begin
    bit busy;
    int hold, acks;
    bit [3:0] o;
    bit [31:0] d;
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb.wbs_sel_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;

    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready_o), 32'd1);
    chk("rst_ctrl", ctrl_o, 32'h0);
    nrst = 1;
    @(negedge clk);

    rd_chk("status_reset", 4'h4, 32'h0000_000A);
    chk("ack_latency", 32'(lat), 32'd1);

    wr(4'h0, 32'hAABB_CC02, 4'b0101);
    rd_chk("ctrl_bytesel", 4'h0, 32'h00BB_0002);
    chk("ctrl_o_bytesel", ctrl_o, 32'h00BB_0002);

    for (int k = 1; k <= 5; k++) wr(4'h8, 32'(k), 4'hF);
    rd_chk("status_tx_full_ovf", 4'h4, 32'h0000_0419);
    tx_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      chk("tx_seq", 32'(tx_data_o), 32'(k));
      @(negedge clk);
    end
    chk("tx_drained", 32'(tx_valid_o), 32'd0);
    tx_ready = 0;
    wr(4'h4, 32'h0000_0010, 4'hF);

    core_push(16'h1234);
    core_push(16'h5678);
    rd_chk("rx_first", 4'hC, 32'h0000_1234);
    rd_chk("rx_second", 4'hC, 32'h0000_5678);
    rd_chk("rx_empty_read", 4'hC, 32'h0);
    rd_chk("status_rx_unf", 4'h4, 32'h0000_002A);
    wr(4'h4, 32'h0000_0020, 4'hF);
    rd_chk("status_unf_cleared", 4'h4, 32'h0000_000A);

    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 1;
    wb.wbs_adr_i = BASE + 32'h10; wb.wbs_dat_i = 32'hFFFF_FFFF; wb.wbs_sel_i = 4'hF;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wb.wbs_ack_o) acks++;
    end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    chk("out_of_window_acks", 32'(acks), 32'd0);
    rd_chk("ctrl_after_oow", 4'h0, 32'h00BB_0002);

    wr(4'h8, 32'h0000_000A, 4'hF);
    wr(4'h8, 32'h0000_000B, 4'hF);
    core_push(16'h0011);
    core_push(16'h0022);
    rd_chk("status_two_each", 4'h4, 32'h0002_0200);
    wr(4'h0, 32'h0000_0003, 4'b0001);
    rd_chk("status_after_clr", 4'h4, 32'h0000_000A);
    rd_chk("ctrl_after_clr", 4'h0, 32'h00BB_0002);

`ifdef TEAM_12_WB_REGIF_IRQ_EN
    chk("irq_idle", 32'(irq_o), 32'd0);
    core_push(16'h0077);
    chk("irq_push_edge", 32'(irq_o), 32'd0);
    @(negedge clk);
    chk("irq_next_cycle", 32'(irq_o), 32'd1);
    rd_chk("rx_irq_drain", 4'hC, 32'h0000_0077);
`endif

    busy = 0; hold = 0;
    for (int c = 0; c < 3000; c++) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = DW'($urandom);
      if (busy) begin
        hold--;
        if (wb.wbs_ack_o || hold == 0) begin
          if (wb.wbs_ack_o)
            $display("rand we=%0d adr=%h rd=%h", wb.wbs_we_i, wb.wbs_adr_i, wb.wbs_dat_o);
          wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
          busy = 0;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        o = {2'($urandom_range(0, 3)), 2'b00};
        d = $urandom;
        wb.wbs_we_i = 1'($urandom_range(0, 1));
        if (o == 4'h0 && wb.wbs_we_i) d[0] = ($urandom_range(0, 15) == 0);
        wb.wbs_dat_i = d;
        wb.wbs_sel_i = 4'($urandom);
        if ($urandom_range(0, 9) == 0)
          wb.wbs_adr_i = (BASE ^ (32'h1 << $urandom_range(4, 31))) + 32'(o);
        else
          wb.wbs_adr_i = BASE + 32'(o);
        wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1;
        busy = 1; hold = 4;
      end
      @(negedge clk);
    end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    tx_ready = 0; rx_valid = 0;
    repeat (2) @(negedge clk);

    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 0; wb.wbs_adr_i = BASE + 32'h4;
    @(posedge clk);
    #2 nrst = 0;
    #1;
    chk("rst_mid_ack", 32'(wb.wbs_ack_o), 32'd0);
    chk("rst_mid_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_mid_rx_ready", 32'(rx_ready_o), 32'd1);
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0;
    @(negedge clk);
    nrst = 1;
    @(negedge clk);
    rd_chk("status_after_rst", 4'h4, 32'h0000_000A);
    rd_chk("ctrl_after_rst", 4'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
